// File: rtl/control_fsm.sv
// Multi-cycle control unit for the CHARIS-style datapath: sequences fetch, decode, execute,
// memory and write-back, and closes the PC loop back to the fetch stage.
module control_fsm #(
    parameter int unsigned OPC_W = 6
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic        ALU_zero,
    output logic        PC_Sel,
    output logic        PC_LdEn,
    output logic        IR_LdEn,
    output logic        RF_B_sel,
    output logic        RF_WrEn,
    output logic        RF_WrData_sel,
    output logic [1:0]  ImmExt,
    output logic        ALU_Bin_sel,
    output logic [3:0]  ALU_func,
    output logic        MEM_WrEn,
    output logic        ByteOp,
    output logic [2:0]  State
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ClsNop,
        ClsAlu,
        ClsBranch,
        ClsLoad,
        ClsStore
    } op_class_e;

    localparam logic [OPC_W-1:0] OpcRtype = OPC_W'(6'b100000);
    localparam logic [OPC_W-1:0] OpcAddi  = OPC_W'(6'b110000);
    localparam logic [OPC_W-1:0] OpcAndi  = OPC_W'(6'b110010);
    localparam logic [OPC_W-1:0] OpcOri   = OPC_W'(6'b110011);
    localparam logic [OPC_W-1:0] OpcLi    = OPC_W'(6'b111000);
    localparam logic [OPC_W-1:0] OpcLui   = OPC_W'(6'b111001);
    localparam logic [OPC_W-1:0] OpcBeq   = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0] OpcBne   = OPC_W'(6'b000001);
    localparam logic [OPC_W-1:0] OpcB     = OPC_W'(6'b111111);
    localparam logic [OPC_W-1:0] OpcLw    = OPC_W'(6'b001111);
    localparam logic [OPC_W-1:0] OpcLb    = OPC_W'(6'b000011);
    localparam logic [OPC_W-1:0] OpcSw    = OPC_W'(6'b011111);
    localparam logic [OPC_W-1:0] OpcSb    = OPC_W'(6'b000111);

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;
    localparam logic [3:0] AluAnd = 4'b0010;
    localparam logic [3:0] AluOr  = 4'b0011;

    localparam logic [1:0] ImmZero    = 2'b00;
    localparam logic [1:0] ImmSext    = 2'b01;
    localparam logic [1:0] ImmSextSh2 = 2'b10;
    localparam logic [1:0] ImmShl16   = 2'b11;

    function automatic op_class_e classify(input logic [OPC_W-1:0] opc);
        op_class_e cls;
        case (opc)
            OpcRtype, OpcAddi, OpcAndi, OpcOri, OpcLi, OpcLui: cls = ClsAlu;
            OpcBeq, OpcBne, OpcB:                             cls = ClsBranch;
            OpcLw, OpcLb:                                     cls = ClsLoad;
            OpcSw, OpcSb:                                     cls = ClsStore;
            default:                                          cls = ClsNop;
        endcase
        return cls;
    endfunction

    state_e           state_q, state_d;
    logic             started_q;
    logic [OPC_W-1:0] opc_q;
    logic [3:0]       func_q;
    op_class_e        live_cls;
    op_class_e        cls_q;

    logic [3:0] alu_func_f;
    logic [1:0] imm_ext_f;
    logic       bin_sel_f;
    logic       b_sel_f;
    logic       byte_f;
    logic       wr_data_sel_f;
    logic       taken;

    // Only the opcode and R-type function field matter to control.
    logic unused_instr_bits;
    assign unused_instr_bits = ^Instr[31-OPC_W:4];

    assign live_cls = classify(Instr[31 -: OPC_W]);
    assign cls_q    = classify(opc_q);
    assign State    = state_q;

    // started_q holds FETCH through the first edge after reset release, so the first
    // FETCH spans a full cycle regardless of where in the cycle Reset was released.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= StFetch;
            started_q <= 1'b0;
            opc_q     <= '0;
            func_q    <= '0;
        end else begin
            started_q <= 1'b1;
            if (started_q) begin
                state_q <= state_d;
            end
            if (state_q == StDecode) begin
                opc_q  <= Instr[31 -: OPC_W];
                func_q <= Instr[3:0];
            end
        end
    end

    // Datapath control fields, decoded from the latched opcode only.
    always_comb begin
        alu_func_f    = AluAdd;
        imm_ext_f     = ImmZero;
        bin_sel_f     = 1'b0;
        b_sel_f       = 1'b0;
        byte_f        = 1'b0;
        wr_data_sel_f = 1'b0;
        taken         = 1'b0;
        case (opc_q)
            OpcRtype: alu_func_f = func_q;
            OpcAddi: begin
                bin_sel_f = 1'b1;
                imm_ext_f = ImmSext;
            end
            OpcAndi: begin
                bin_sel_f  = 1'b1;
                alu_func_f = AluAnd;
            end
            OpcOri: begin
                bin_sel_f  = 1'b1;
                alu_func_f = AluOr;
            end
            OpcLi: begin
                bin_sel_f = 1'b1;
                imm_ext_f = ImmSext;
            end
            OpcLui: begin
                bin_sel_f = 1'b1;
                imm_ext_f = ImmShl16;
            end
            OpcBeq, OpcBne, OpcB: begin
                b_sel_f    = 1'b1;
                alu_func_f = AluSub;
                imm_ext_f  = ImmSextSh2;
                if (opc_q == OpcBeq) begin
                    taken = ALU_zero;
                end else if (opc_q == OpcBne) begin
                    taken = !ALU_zero;
                end else begin
                    taken = 1'b1;
                end
            end
            OpcLw, OpcLb: begin
                bin_sel_f     = 1'b1;
                imm_ext_f     = ImmSext;
                wr_data_sel_f = 1'b1;
                byte_f        = (opc_q == OpcLb);
            end
            OpcSw, OpcSb: begin
                b_sel_f   = 1'b1;
                bin_sel_f = 1'b1;
                imm_ext_f = ImmSext;
                byte_f    = (opc_q == OpcSb);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        PC_Sel        = 1'b0;
        PC_LdEn       = 1'b0;
        IR_LdEn       = 1'b0;
        RF_B_sel      = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrData_sel = 1'b0;
        ImmExt        = ImmZero;
        ALU_Bin_sel   = 1'b0;
        ALU_func      = AluAdd;
        MEM_WrEn      = 1'b0;
        ByteOp        = 1'b0;

        if (state_q == StExec || state_q == StMem || state_q == StWb) begin
            RF_B_sel      = b_sel_f;
            RF_WrData_sel = wr_data_sel_f;
            ImmExt        = imm_ext_f;
            ALU_Bin_sel   = bin_sel_f;
            ALU_func      = alu_func_f;
            ByteOp        = byte_f;
        end

        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                IR_LdEn = 1'b1;
                if (live_cls == ClsNop) begin
                    PC_LdEn = 1'b1;
                    state_d = StFetch;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                case (cls_q)
                    ClsBranch: begin
                        PC_LdEn = 1'b1;
                        PC_Sel  = taken;
                        state_d = StFetch;
                    end
                    ClsLoad, ClsStore: state_d = StMem;
                    ClsAlu:            state_d = StWb;
                    default:           state_d = StFetch;
                endcase
            end
            StMem: begin
                if (cls_q == ClsStore) begin
                    MEM_WrEn = 1'b1;
                    PC_LdEn  = 1'b1;
                    state_d  = StFetch;
                end else if (cls_q == ClsLoad) begin
                    state_d = StWb;
                end else begin
                    state_d = StFetch;
                end
            end
            StWb: begin
                RF_WrEn = 1'b1;
                PC_LdEn = 1'b1;
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: a spec-derived model pushes per-cycle expected
// outputs into a scoreboard queue, which each scenario drains against the DUT.
module tb_control_fsm;

    logic        Clk;
    logic        Reset;
    logic [31:0] Instr;
    logic        ALU_zero;
    logic        PC_Sel;
    logic        PC_LdEn;
    logic        IR_LdEn;
    logic        RF_B_sel;
    logic        RF_WrEn;
    logic        RF_WrData_sel;
    logic [1:0]  ImmExt;
    logic        ALU_Bin_sel;
    logic [3:0]  ALU_func;
    logic        MEM_WrEn;
    logic        ByteOp;
    logic [2:0]  State;

    int checks;
    int failures;

    // Packed as {State, PC_Sel, PC_LdEn, IR_LdEn, RF_B_sel, RF_WrEn, RF_WrData_sel,
    //            ImmExt, ALU_Bin_sel, ALU_func, MEM_WrEn, ByteOp}
    typedef struct packed {
        logic [31:0] instr;
        logic        set_instr;
        logic        zero;
        logic [17:0] exp;
    } rec_t;

    rec_t sb_q[$];

    control_fsm #(.OPC_W(6)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Instr         (Instr),
        .ALU_zero      (ALU_zero),
        .PC_Sel        (PC_Sel),
        .PC_LdEn       (PC_LdEn),
        .IR_LdEn       (IR_LdEn),
        .RF_B_sel      (RF_B_sel),
        .RF_WrEn       (RF_WrEn),
        .RF_WrData_sel (RF_WrData_sel),
        .ImmExt        (ImmExt),
        .ALU_Bin_sel   (ALU_Bin_sel),
        .ALU_func      (ALU_func),
        .MEM_WrEn      (MEM_WrEn),
        .ByteOp        (ByteOp),
        .State         (State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] pk(input logic [2:0] st, input logic pcs, input logic pcl,
                                       input logic ir, input logic bsel, input logic rfw,
                                       input logic wds, input logic [1:0] imm, input logic bin,
                                       input logic [3:0] fn, input logic mw, input logic bo);
        return {st, pcs, pcl, ir, bsel, rfw, wds, imm, bin, fn, mw, bo};
    endfunction

    function automatic logic [17:0] observed();
        return {State, PC_Sel, PC_LdEn, IR_LdEn, RF_B_sel, RF_WrEn, RF_WrData_sel,
                ImmExt, ALU_Bin_sel, ALU_func, MEM_WrEn, ByteOp};
    endfunction

    // Model: push the expected cycle-by-cycle outputs of one instruction.
    task automatic push_instr(input logic [31:0] ins, input logic zero);
        logic [5:0] opc;
        logic [3:0] fn;
        logic [1:0] imm;
        logic       bin, bsel, bo, wds, taken;
        int         kind; // 0 nop, 1 alu, 2 branch, 3 load, 4 store
        rec_t       r;
        opc = ins[31:26];
        fn = 4'b0000; imm = 2'b00; bin = 1'b0; bsel = 1'b0; bo = 1'b0; wds = 1'b0;
        taken = 1'b0; kind = 0;
        case (opc)
            6'b100000: begin kind = 1; fn = ins[3:0]; end
            6'b110000: begin kind = 1; bin = 1'b1; imm = 2'b01; end
            6'b110010: begin kind = 1; bin = 1'b1; fn = 4'b0010; end
            6'b110011: begin kind = 1; bin = 1'b1; fn = 4'b0011; end
            6'b111000: begin kind = 1; bin = 1'b1; imm = 2'b01; end
            6'b111001: begin kind = 1; bin = 1'b1; imm = 2'b11; end
            6'b000000: begin kind = 2; bsel = 1'b1; fn = 4'b0001; imm = 2'b10; taken = zero; end
            6'b000001: begin kind = 2; bsel = 1'b1; fn = 4'b0001; imm = 2'b10; taken = !zero; end
            6'b111111: begin kind = 2; bsel = 1'b1; fn = 4'b0001; imm = 2'b10; taken = 1'b1; end
            6'b001111: begin kind = 3; bin = 1'b1; imm = 2'b01; wds = 1'b1; end
            6'b000011: begin kind = 3; bin = 1'b1; imm = 2'b01; wds = 1'b1; bo = 1'b1; end
            6'b011111: begin kind = 4; bin = 1'b1; imm = 2'b01; bsel = 1'b1; end
            6'b000111: begin kind = 4; bin = 1'b1; imm = 2'b01; bsel = 1'b1; bo = 1'b1; end
            default:   kind = 0;
        endcase
        r.instr = ins; r.set_instr = 1'b1; r.zero = 1'($urandom);
        r.exp = pk(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 4'b0000, 0, 0);
        sb_q.push_back(r);
        r.set_instr = 1'b0; r.zero = 1'($urandom);
        r.exp = pk(3'd1, 0, kind == 0, 1, 0, 0, 0, 2'b00, 0, 4'b0000, 0, 0);
        sb_q.push_back(r);
        if (kind != 0) begin
            // Scramble Instr in EXEC: later states must use the latched opcode.
            r.instr = $urandom; r.set_instr = 1'b1; r.zero = zero;
            r.exp = pk(3'd2, (kind == 2) ? taken : 1'b0, kind == 2, 0, bsel, 0, wds, imm, bin,
                       fn, 0, bo);
            sb_q.push_back(r);
            r.set_instr = 1'b0;
            if (kind == 3 || kind == 4) begin
                r.zero = 1'($urandom);
                r.exp = pk(3'd3, 0, kind == 4, 0, bsel, 0, wds, imm, bin, fn, kind == 4, bo);
                sb_q.push_back(r);
            end
            if (kind == 1 || kind == 3) begin
                r.zero = 1'($urandom);
                r.exp = pk(3'd4, 0, 1, 0, bsel, 1, wds, imm, bin, fn, 0, bo);
                sb_q.push_back(r);
            end
        end
    endtask

    task automatic test_reset();
        logic [17:0] obs;
        rec_t rec;
        int cyc;
        Reset = 1'b0;
        Instr = $urandom;
        ALU_zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            #1;
            obs = observed();
            checks++;
            if (obs !== 18'h0) begin
                failures++;
                $display("FAIL reset_hold cyc %0d: got %h required %h", i, obs, 18'h0);
            end
        end
        @(negedge Clk);
        Reset = 1'b1;
        push_instr({6'b110000, 26'h0012345}, 1'b0);
        cyc = 0;
        while (sb_q.size() > 0) begin
            rec = sb_q.pop_front();
            @(negedge Clk);
            if (rec.set_instr) Instr = rec.instr;
            ALU_zero = rec.zero;
            #1;
            obs = observed();
            checks++;
            if (obs !== rec.exp) begin
                failures++;
                $display("FAIL reset_release cyc %0d: got %h required %h", cyc, obs, rec.exp);
            end
            cyc++;
        end
    endtask

    task automatic test_rtype();
        logic [17:0] obs;
        rec_t rec;
        int cyc;
        push_instr(32'h8000_0000, 1'b1);
        push_instr({6'b100000, 22'($urandom), 4'b0001}, 1'b0);
        push_instr({6'b100000, 22'($urandom), 4'b0011}, 1'b1);
        cyc = 0;
        while (sb_q.size() > 0) begin
            rec = sb_q.pop_front();
            @(negedge Clk);
            if (rec.set_instr) Instr = rec.instr;
            ALU_zero = rec.zero;
            #1;
            obs = observed();
            checks++;
            if (obs !== rec.exp) begin
                failures++;
                $display("FAIL rtype cyc %0d: got %h required %h", cyc, obs, rec.exp);
            end
            cyc++;
        end
    endtask

    task automatic test_branch();
        logic [17:0] obs;
        rec_t rec;
        int cyc;
        push_instr({6'b000000, 26'h0000010}, 1'b1);
        push_instr({6'b000000, 26'h0000010}, 1'b0);
        push_instr({6'b000001, 26'($urandom)}, 1'b1);
        push_instr({6'b000001, 26'($urandom)}, 1'b0);
        push_instr({6'b111111, 26'($urandom)}, 1'b0);
        cyc = 0;
        while (sb_q.size() > 0) begin
            rec = sb_q.pop_front();
            @(negedge Clk);
            if (rec.set_instr) Instr = rec.instr;
            ALU_zero = rec.zero;
            #1;
            obs = observed();
            checks++;
            if (obs !== rec.exp) begin
                failures++;
                $display("FAIL branch cyc %0d: got %h required %h", cyc, obs, rec.exp);
            end
            cyc++;
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] obs;
        rec_t rec;
        int cyc;
        logic [5:0] opcs [9];
        opcs = '{6'b110000, 6'b110010, 6'b110011, 6'b111000, 6'b111001,
                 6'b000011, 6'b011111, 6'b001111, 6'b000111};
        push_instr({6'b001111, 26'($urandom)}, 1'b0);
        push_instr({6'b000111, 26'($urandom)}, 1'b1);
        foreach (opcs[i]) push_instr({opcs[i], 26'($urandom)}, 1'($urandom));
        cyc = 0;
        while (sb_q.size() > 0) begin
            rec = sb_q.pop_front();
            @(negedge Clk);
            if (rec.set_instr) Instr = rec.instr;
            ALU_zero = rec.zero;
            #1;
            obs = observed();
            checks++;
            if (obs !== rec.exp) begin
                failures++;
                $display("FAIL back_to_back cyc %0d: got %h required %h", cyc, obs, rec.exp);
            end
            cyc++;
        end
    endtask

    task automatic test_illegal();
        logic [17:0] obs;
        rec_t rec;
        int cyc;
        push_instr({6'b010101, 26'($urandom)}, 1'b1);
        push_instr({6'b101010, 26'($urandom)}, 1'b0);
        push_instr({6'b100000, 22'($urandom), 4'b0010}, 1'b0);
        cyc = 0;
        while (sb_q.size() > 0) begin
            rec = sb_q.pop_front();
            @(negedge Clk);
            if (rec.set_instr) Instr = rec.instr;
            ALU_zero = rec.zero;
            #1;
            obs = observed();
            checks++;
            if (obs !== rec.exp) begin
                failures++;
                $display("FAIL illegal cyc %0d: got %h required %h", cyc, obs, rec.exp);
            end
            cyc++;
        end
    endtask

    task automatic test_mid_reset();
        logic [17:0] obs;
        rec_t rec;
        int cyc;
        push_instr({6'b011111, 26'($urandom)}, 1'b0);
        cyc = 0;
        while (sb_q.size() > 0) begin
            rec = sb_q.pop_front();
            @(negedge Clk);
            if (rec.set_instr) Instr = rec.instr;
            ALU_zero = rec.zero;
            #1;
            obs = observed();
            checks++;
            if (obs !== rec.exp) begin
                failures++;
                $display("FAIL mid_reset_sw cyc %0d: got %h required %h", cyc, obs, rec.exp);
            end
            cyc++;
        end
        // Now in MEM of sw with MEM_WrEn high; pull reset mid-cycle.
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if (MEM_WrEn !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_memwr: got %b required 0", MEM_WrEn);
        end
        obs = observed();
        checks++;
        if (obs !== 18'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got %h required %h", obs, 18'h0);
        end
        @(negedge Clk);
        Reset = 1'b1;
        push_instr({6'b001111, 26'($urandom)}, 1'b1);
        cyc = 0;
        while (sb_q.size() > 0) begin
            rec = sb_q.pop_front();
            @(negedge Clk);
            if (rec.set_instr) Instr = rec.instr;
            ALU_zero = rec.zero;
            #1;
            obs = observed();
            checks++;
            if (obs !== rec.exp) begin
                failures++;
                $display("FAIL mid_reset_recover cyc %0d: got %h required %h", cyc, obs, rec.exp);
            end
            cyc++;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_rtype();
        test_branch();
        test_back_to_back();
        test_illegal();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle control unit for the CHARIS-style datapath. It sits directly downstream of the instruction fetch stage, consumes its `Instr` word, and closes the loop by driving that stage's `PC_Sel` and `PC_LdEn`. It also sequences the decode, execute, memory and write-back controls, so each instruction takes 3–5 clock cycles.

## Interface
Parameters:
- `OPC_W`, 6: opcode field width, `Instr[31:26]`.

Ports (clock and reset first):
- `Clk` in 1: single system clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `Instr` in 32: instruction word from fetch; valid from the cycle after the one in which PC was stable.
- `ALU_zero` in 1: ALU zero flag from the datapath.
- `PC_Sel` out 1: 0 selects PC+4, 1 selects PC+4+immediate.
- `PC_LdEn` out 1: PC load enable.
- `IR_LdEn` out 1: instruction register capture.
- `RF_B_sel` out 1: register-file read port B; 0 reads rt `[15:11]`, 1 reads rd `[20:16]`.
- `RF_WrEn` out 1: register-file write enable; destination is rd.
- `RF_WrData_sel` out 1: 0 selects ALU result, 1 selects memory data.
- `ImmExt` out 2: 00 zero-fill, 01 sign-extend, 10 sign-extend then shift left 2, 11 shift left 16.
- `ALU_Bin_sel` out 1: 0 selects register B, 1 selects immediate.
- `ALU_func` out 4: 0000 add, 0001 sub, 0010 and, 0011 or.
- `MEM_WrEn` out 1: data-memory write enable.
- `ByteOp` out 1: 1 selects a byte access, 0 a word access.
- `State` out 3: current state, for debug and verification.

## Operation
- States and `State` encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. No other encoding is reachable; any other value returns to FETCH.
- Opcode is latched at the end of DECODE. All later states decode from this latched opcode, never from live `Instr`.
- Opcodes, paths and cycle counts:
  - R-type 100000: FETCH→DECODE→EXEC→WB, 4 cycles. `ALU_func`=`Instr[3:0]`.
  - addi 110000, andi 110010, ori 110011: FETCH→DECODE→EXEC→WB, 4 cycles. `ALU_Bin_sel`=1. `ImmExt`=01 for addi, 00 for andi/ori. `ALU_func`=add/and/or respectively.
  - li 111000 and lui 111001: add with immediate, 4 cycles. `ImmExt`=01 for li, 11 for lui. Both are encoded with rs=r0.
  - beq 000000 and bne 000001: FETCH→DECODE→EXEC, 3 cycles. `RF_B_sel`=1, `ALU_func`=sub, `ImmExt`=10.
  - b 111111: same path and controls as beq, but always taken.
  - lw 001111 and lb 000011: FETCH→DECODE→EXEC→MEM→WB, 5 cycles. `ImmExt`=01, `ALU_Bin_sel`=1, add. `RF_WrData_sel`=1 in WB. `ByteOp`=1 for lb.
  - sw 011111 and sb 000111: FETCH→DECODE→EXEC→MEM, 4 cycles. `RF_B_sel`=1. `MEM_WrEn`=1 in MEM. `ByteOp`=1 for sb.
  - Any other opcode: DECODE→FETCH as a NOP. `PC_LdEn`=1 and `PC_Sel`=0 in DECODE.
- Per-state controls:
  - FETCH: all outputs 0; waits for the synchronous IMEM read.
  - DECODE: `IR_LdEn`=1.
  - `RF_WrEn`=1 only in WB.
  - `MEM_WrEn`=1 only in MEM.
- PC update: `PC_LdEn`=1 for exactly one cycle, in the last state of every instruction.
- Branch PC select: in EXEC, `PC_Sel` is combinational (Mealy).
  - beq: `PC_Sel`=`ALU_zero`.
  - bne: `PC_Sel`=!`ALU_zero`.
  - b: `PC_Sel`=1.
- `PC_Sel` is 0 in every other case.
- Control-field values (`ALU_func`, `ImmExt`, `ALU_Bin_sel`, `RF_B_sel`, `ByteOp`, `RF_WrData_sel`) are held from EXEC through the final state.

## Timing
- Reset asserted (low) takes effect immediately: state goes to FETCH and every output is 0, including `State`=0.
- Reset release: the first FETCH occupies the first full cycle after deassertion.
- Reset asserted mid-instruction: any pending `RF_WrEn`, `MEM_WrEn` or `PC_LdEn` is suppressed in that same cycle.
- `State` transitions occur on the rising edge of `Clk` only. The FSM never stalls.
- `PC_LdEn` high at edge N means fetch sees the new PC in cycle N+1 (FETCH). `Instr` is valid in DECODE.
- No write enable is ever asserted in FETCH or DECODE. Consequently, back-to-back instructions have no overlap.

## Test plan
- Reset: hold Reset=0 for 3 cycles, then release. Required: `State`=0 and all outputs 0 during reset; `IR_LdEn`=1 in cycle 2 after release.
- R-type add, `Instr`=0x8000_0000-class with func 0000. Required: states 0,1,2,4; `RF_WrEn`=1 only in WB; `PC_LdEn`=1 in WB with `PC_Sel`=0.
- beq, once with `ALU_zero`=1 and once with 0. Required: 3-cycle path; in EXEC `PC_LdEn`=1 with `PC_Sel`=1 for zero=1 and 0 for zero=0; `RF_WrEn` never asserted.
- lw then sb, back-to-back. Required: lw takes 5 cycles with `RF_WrData_sel`=1 in WB; sb takes 4 cycles with `MEM_WrEn`=1 and `ByteOp`=1 in MEM.
- Illegal opcode 010101. Required: DECODE→FETCH, with `PC_LdEn`=1 and `PC_Sel`=0 in DECODE.
- Reset pulled low during the MEM state of sw. Required: `MEM_WrEn` drops to 0 asynchronously and `State`=0.
